// File: rtl/video_pattern_gen_pkg.sv
// Shared video definitions: pattern encodings, colour-bar palette and
// 1280x720@60 timing used as parameter defaults.
package video_pattern_gen_pkg;

  typedef enum logic [1:0] {
    PAT_BAR   = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  // Bar colours as {R,G,B} on/off masks, expanded to DATA_W by the user.
  localparam logic [2:0] COL_WHITE   = 3'b111;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_BLACK   = 3'b000;

  localparam int VID_H_SYNC   = 40;
  localparam int VID_H_BP     = 220;
  localparam int VID_H_ACTIVE = 1280;
  localparam int VID_H_FP     = 110;
  localparam int VID_V_SYNC   = 5;
  localparam int VID_V_BP     = 20;
  localparam int VID_V_ACTIVE = 720;
  localparam int VID_V_FP     = 5;

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = COL_WHITE;
      3'd1:    m = COL_YELLOW;
      3'd2:    m = COL_CYAN;
      3'd3:    m = COL_GREEN;
      3'd4:    m = COL_MAGENTA;
      3'd5:    m = COL_RED;
      3'd6:    m = COL_BLUE;
      default: m = COL_BLACK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/video_pattern_gen_timing_ctr.sv
// video_timing_ctr: raster counters, registered sync/de/position outputs,
// plus the pre-register position view the pattern logic registers from.
module video_timing_ctr
  import video_pattern_gen_pkg::*;
#(
  parameter int   H_SYNC   = VID_H_SYNC,
  parameter int   H_BP     = VID_H_BP,
  parameter int   H_ACTIVE = VID_H_ACTIVE,
  parameter int   H_FP     = VID_H_FP,
  parameter int   V_SYNC   = VID_V_SYNC,
  parameter int   V_BP     = VID_V_BP,
  parameter int   V_ACTIVE = VID_V_ACTIVE,
  parameter int   V_FP     = VID_V_FP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        i_pixel_clk,
  input  logic        i_reset,
  input  logic        i_en,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [10:0] o_xpos,
  output logic [10:0] o_ypos,
  output logic        o_frame_start,
  output logic        o_pre_de,
  output logic [10:0] o_pre_xpos,
  output logic [10:0] o_pre_ypos,
  output logic        o_pre_origin
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_AS   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_AE   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_AS   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_AE   = VW'(V_SYNC + V_BP + V_ACTIVE);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_de;
  logic          w_origin;
  logic [10:0]   w_x;
  logic [10:0]   w_y;

  assign w_de     = (r_h >= H_AS) && (r_h < H_AE) && (r_v >= V_AS) && (r_v < V_AE);
  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_x      = w_de ? 11'(r_h - H_AS) : 11'd0;
  assign w_y      = w_de ? 11'(r_v - V_AS) : 11'd0;

  assign o_pre_de     = w_de;
  assign o_pre_xpos   = w_x;
  assign o_pre_ypos   = w_y;
  assign o_pre_origin = i_en && w_origin;

  // Disabled behaves like reset except the pattern latch, which the top keeps.
  always_ff @(posedge i_pixel_clk) begin
    if (i_reset || !i_en) begin
      r_h           <= '0;
      r_v           <= '0;
      o_hs          <= ~SYNC_POL;
      o_vs          <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_xpos        <= '0;
      o_ypos        <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_hs          <= (r_h < H_SE) ? SYNC_POL : ~SYNC_POL;
      o_vs          <= (r_v < V_SE) ? SYNC_POL : ~SYNC_POL;
      o_de          <= w_de;
      o_xpos        <= w_x;
      o_ypos        <= w_y;
      o_frame_start <= w_origin;
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: colour bars, grey ramp, checkerboard or solid
// colour, with the selection latched once per frame at the raster origin.
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int   H_SYNC     = VID_H_SYNC,
  parameter int   H_BP       = VID_H_BP,
  parameter int   H_ACTIVE   = VID_H_ACTIVE,
  parameter int   H_FP       = VID_H_FP,
  parameter int   V_SYNC     = VID_V_SYNC,
  parameter int   V_BP       = VID_V_BP,
  parameter int   V_ACTIVE   = VID_V_ACTIVE,
  parameter int   V_FP       = VID_V_FP,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   DATA_W     = 8,
  parameter int   CHECK_LOG2 = 5
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            pattern_sel,
  input  logic [3*DATA_W-1:0]   solid_rgb,
  output logic                  video_hs,
  output logic                  video_vs,
  output logic                  video_de,
  output logic [3*DATA_W-1:0]   video_rgb,
  output logic [10:0]           pixel_xpos,
  output logic [10:0]           pixel_ypos,
  output logic                  frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic                w_pre_de;
  logic                w_pre_origin;
  logic [10:0]         w_pre_x;
  logic [10:0]         w_pre_y;
  pattern_e            r_pat;
  logic [3*DATA_W-1:0] r_solid;
  logic [3*DATA_W-1:0] r_rgb;
  pattern_e            w_pat;
  logic [3*DATA_W-1:0] w_solid;
  logic [10:0]         w_bar;
  logic [2:0]          w_mask;
  logic [3*DATA_W-1:0] w_pix;

  video_timing_ctr #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .i_pixel_clk   (pixel_clk),
    .i_reset       (reset),
    .i_en          (en),
    .o_hs          (video_hs),
    .o_vs          (video_vs),
    .o_de          (video_de),
    .o_xpos        (pixel_xpos),
    .o_ypos        (pixel_ypos),
    .o_frame_start (frame_start),
    .o_pre_de      (w_pre_de),
    .o_pre_xpos    (w_pre_x),
    .o_pre_ypos    (w_pre_y),
    .o_pre_origin  (w_pre_origin)
  );

  // At the origin the freshly sampled selection applies to that same pixel.
  assign w_pat   = w_pre_origin ? pattern_e'(pattern_sel) : r_pat;
  assign w_solid = w_pre_origin ? solid_rgb : r_solid;

  always_comb begin
    w_bar  = w_pre_x / 11'(BAR_W);
    w_mask = bar_mask((w_bar > 11'd7) ? 3'd7 : w_bar[2:0]);
    w_pix  = '0;
    case (w_pat)
      PAT_BAR:   w_pix = {{DATA_W{w_mask[2]}}, {DATA_W{w_mask[1]}}, {DATA_W{w_mask[0]}}};
      PAT_RAMP:  w_pix = {3{w_pre_x[DATA_W-1:0]}};
      PAT_CHECK: w_pix = {(3*DATA_W){w_pre_x[CHECK_LOG2] ^ w_pre_y[CHECK_LOG2]}};
      PAT_SOLID: w_pix = w_solid;
      default:   w_pix = '0;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_pat   <= PAT_BAR;
      r_solid <= '0;
      r_rgb   <= '0;
    end else begin
      if (w_pre_origin) begin
        r_pat   <= pattern_e'(pattern_sel);
        r_solid <= solid_rgb;
      end
      r_rgb <= (en && w_pre_de) ? w_pix : '0;
    end
  end

  assign video_rgb = r_rgb;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench: small raster, randomized pattern/en/reset stimulus
// checked every cycle against a frame-time arithmetic reference model.
module tb_video_pattern_gen;

  localparam int HS = 2, HB = 2, HA = 20, HF = 2;
  localparam int VS = 1, VB = 1, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int DW = 4;
  localparam int CL = 1;
  localparam logic POL = 1'b0;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic        video_hs, video_vs, video_de, frame_start;
  logic [11:0] video_rgb;
  logic [10:0] pixel_xpos, pixel_ypos;

  video_pattern_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .SYNC_POL(POL), .DATA_W(DW), .CHECK_LOG2(CL)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .en(en),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_rgb(video_rgb), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad = 0;
  int t = 0;
  int lpat = 0;
  logic [11:0] lsol = '0;
  int fs_seen = 0, de_seen = 0, hs_seen = 0, solid_seen = 0;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic logic [11:0] pix(int pat, logic [11:0] sol, int x, int y);
    int idx;
    logic [3:0] r;
    case (pat)
      0: begin
        idx = x / (HA / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      1: begin
        r = 4'(x % 16);
        return {r, r, r};
      end
      2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return sol;
    endcase
  endfunction

  task automatic chk(string tag, int got, int exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: predict from current inputs, clock, compare all outputs.
  task automatic step(string tag);
    logic e_hs, e_vs, e_de, e_fs;
    logic [11:0] e_rgb;
    logic [10:0] e_x, e_y;
    logic [37:0] got, exp;
    int h, v;
    e_hs = ~POL; e_vs = ~POL; e_de = 0; e_fs = 0; e_rgb = '0; e_x = '0; e_y = '0;
    if (reset || !en) begin
      t = 0;
      if (reset) begin
        lpat = 0;
        lsol = '0;
      end
    end else begin
      h = t % HT;
      v = t / HT;
      if (t == 0) begin
        lpat = int'(pattern_sel);
        lsol = solid_rgb;
      end
      e_hs = (h < HS) ? POL : ~POL;
      e_vs = (v < VS) ? POL : ~POL;
      e_de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      e_fs = (t == 0);
      if (e_de) begin
        e_x   = 11'(h - (HS + HB));
        e_y   = 11'(v - (VS + VB));
        e_rgb = pix(lpat, lsol, h - (HS + HB), v - (VS + VB));
      end
      t = (t + 1) % FT;
    end
    exp = {e_hs, e_vs, e_de, e_rgb, e_x, e_y, e_fs};
    @(posedge pixel_clk);
    #1;
    got = {video_hs, video_vs, video_de, video_rgb, pixel_xpos, pixel_ypos, frame_start};
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, t);
    end
    if (frame_start) fs_seen++;
    if (video_de) de_seen++;
    if (video_hs === POL) hs_seen++;
    if (video_de && video_rgb === 12'h123) solid_seen++;
  endtask

  task automatic clear_stats();
    fs_seen = 0; de_seen = 0; hs_seen = 0; solid_seen = 0;
  endtask

  int en_bad;

  initial begin
    reset = 1'b1; en = 1'b0; pattern_sel = 2'd0; solid_rgb = 12'h000;
    @(negedge pixel_clk);
    repeat (3) step("reset_state");

    // First frame: colour bars, full-frame statistics.
    reset = 1'b0; en = 1'b1;
    step("start");
    chk("first_frame_start", int'(frame_start), 1);
    clear_stats();
    repeat (FT) step("bars");
    chk("de_per_frame", de_seen, HA * VA);
    chk("hs_active_per_frame", hs_seen, HS * VT);
    chk("fs_per_frame", fs_seen, 1);

    // Ramp (wrap at xpos 16) takes effect at the next frame boundary.
    pattern_sel = 2'd1;
    repeat (FT + 40) step("ramp");

    // Mid-frame switch to solid: remainder stays ramp, next frame solid.
    pattern_sel = 2'd3; solid_rgb = 12'h123;
    for (int i = 0; i < FT && t != 0; i++) step("solid_wait");
    clear_stats();
    repeat (FT) step("solid");
    chk("solid_de_cycles", solid_seen, HA * VA);

    pattern_sel = 2'd2;
    repeat (FT) step("check");

    // Randomized pattern/colour changes.
    repeat (6 * FT) begin
      if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) solid_rgb = 12'($urandom);
      step("rand_pat");
    end

    // Reset on line 2, held 3 cycles.
    for (int i = 0; i < 2 * FT && t != 2 * HT + 5; i++) step("to_line2");
    chk("reached_line2", t, 2 * HT + 5);
    reset = 1'b1;
    repeat (3) step("mid_reset");
    reset = 1'b0;
    clear_stats();
    step("after_reset");
    chk("fs_after_reset", int'(frame_start), 1);
    repeat (FT - 1) step("after_reset_frame");
    chk("fs_once_after_reset", fs_seen, 1);

    // en low for 10 cycles mid-line.
    for (int i = 0; i < 2 * FT && t != 3 * HT + 10; i++) step("to_midline");
    chk("reached_midline", t, 3 * HT + 10);
    en = 1'b0;
    en_bad = 0;
    repeat (10) begin
      step("en_low");
      if (video_de !== 1'b0 || video_hs === POL || video_vs === POL) en_bad++;
    end
    chk("idle_while_en_low", en_bad, 0);
    en = 1'b1;
    step("en_rise");
    chk("fs_after_en_rise", int'(frame_start), 1);
    clear_stats();
    repeat (FT) step("frame_after_en");
    chk("de_after_en", de_seen, HA * VA);

    // Random en / reset / pattern traffic.
    repeat (1500) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) solid_rgb = 12'($urandom);
      step("rand_ctl");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_SYNC, 40, hsync width in pixels
- H_BP, 220, horizontal back porch
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- V_SYNC, 5, vsync width in lines
- V_BP, 20, vertical back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- SYNC_POL, 1, sync active level: 1 = high, 0 = low
- DATA_W, 8, bits per colour component
- CHECK_LOG2, 5, log2 of checkerboard square size
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- pixel_clk, in, 1, pixel clock; the block's only clock
- reset, in, 1, synchronous, active-high reset
- en, in, 1, run enable
- pattern_sel, in, 2, 0 = colour bars, 1 = grey ramp, 2 = checkerboard, 3 = solid
- solid_rgb, in, 3*DATA_W, colour used in solid mode, as {R,G,B}
- video_hs, out, 1, horizontal sync
- video_vs, out, 1, vertical sync
- video_de, out, 1, data enable
- video_rgb, out, 3*DATA_W, pixel data as {R,G,B}
- pixel_xpos, out, 11, active column
- pixel_ypos, out, 11, active row
- frame_start, out, 1, one-cycle pulse on the first cycle of each frame

Function
REQ-003 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment on each h_cnt wrap and itself wrap to 0 after V_TOTAL-1.
REQ-005 Region order within a line and within a frame SHALL be sync, back porch, active, front porch.
REQ-006 Active region:
- H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE
- V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE
REQ-007 All outputs SHALL be registered and SHALL reflect counter state (h_cnt, v_cnt) exactly one cycle later.
REQ-008 Sync levels:
- video_hs = SYNC_POL while h_cnt < H_SYNC, else ~SYNC_POL
- video_vs = SYNC_POL while v_cnt < V_SYNC, else ~SYNC_POL
REQ-009 video_de SHALL be 1 only when both the horizontal and vertical counts are active.
REQ-010 Positions:
- pixel_xpos = h_cnt-(H_SYNC+H_BP), pixel_ypos = v_cnt-(V_SYNC+V_BP) when video_de = 1
- both SHALL be 0 otherwise
REQ-011 video_rgb SHALL be 0 whenever video_de = 0.
REQ-012 The active pattern SHALL be taken from pattern_sel, and solid_rgb SHALL be sampled, only when h_cnt = 0 and v_cnt = 0; changes mid-frame take effect from the next frame.
REQ-013 Colour bars:
- 8 bars, each BAR_W = H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black
- component values are all-ones or 0
- bar index = min(xpos/BAR_W, 7), so bar 7 absorbs the remainder
REQ-014 Grey ramp: R = G = B = xpos[DATA_W-1:0], wrapping every 2^DATA_W pixels.
REQ-015 Checkerboard: white when xpos[CHECK_LOG2] XOR ypos[CHECK_LOG2] = 1, else black.
REQ-016 Solid: video_rgb = the latched solid_rgb.
REQ-017 frame_start SHALL be 1 for exactly one cycle, in the output cycle corresponding to h_cnt = 0, v_cnt = 0.
REQ-018 en = 0 SHALL:
- clear h_cnt and v_cnt to 0 and hold them there
- drive outputs to their idle/reset values from the next cycle
REQ-019 A 0->1 transition of en SHALL start a fresh frame at (0,0), and frame_start SHALL assert one cycle after en rises.

Reset
REQ-020 While reset = 1 at a pixel_clk edge:
- h_cnt = 0 and v_cnt = 0
- video_de = 0, video_rgb = 0, pixel_xpos = 0, pixel_ypos = 0, frame_start = 0
- video_hs = ~SYNC_POL and video_vs = ~SYNC_POL
- latched pattern = 0 (colour bars), latched solid colour = 0
REQ-021 Reset SHALL take priority over en.
REQ-022 Reset asserted mid-frame SHALL abort the frame; the first frame after release restarts at (0,0).

Structure
REQ-023 A shared video package SHALL hold:
- pattern_sel encodings (PAT_BAR, PAT_RAMP, PAT_CHECK, PAT_SOLID)
- the eight bar colour constants
- the 1280x720@60 timing constants used as parameter defaults
REQ-024 The block SHALL contain one sub-module, video_timing_ctr, which holds the counters, sync/de/position generation, and the en/reset handling.
REQ-025 The pattern logic SHALL live in video_pattern_gen and consume the positions from video_timing_ctr.

Verification
REQ-026 Default parameters, en = 1, one full frame:
- 1650 cycles per line and 1237500 cycles per frame
- hs low for 40 cycles per line (SYNC_POL = 0 run)
- de high for exactly 1280x720 cycles
REQ-027 Small config (H 2/2/16/2, V 1/1/4/1), colour bars, BAR_W = 2:
- xpos 0,1 -> FFFFFF
- xpos 2 -> FFFF00
- xpos 14,15 -> 000000
REQ-028 Ramp mode, H_ACTIVE = 300: xpos 255 -> 0xFFFFFF and xpos 256 -> 0x000000.
REQ-029 Switch pattern_sel from 0 to 3 (solid_rgb = 0x123456) mid-frame:
- the remainder of the frame stays colour bars
- the next frame outputs 0x123456 on every de cycle
REQ-030 Reset asserted on line 2, held 3 cycles:
- all outputs at reset values during reset
- frame_start pulses exactly once, at the first output cycle after reset release
- vs timing restarts from v_cnt = 0
REQ-031 en dropped for 10 cycles mid-line:
- de = 0 and no sync asserted while en = 0
- on en rising, frame_start one cycle later and a full frame follows
